// File: rtl/mem_access_unit.sv
// mem_access_unit: turns CPU load/store requests into word transactions on a
// data RAM with one combinational read port and one synchronous write port.
// Loads are lane-selected and extended; sub-word stores do read-modify-write.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic        r_we;

    logic        w_misaligned;
    logic        w_is_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // The write strobe is masked by reset so a reset edge can never commit a write.
    assign ram_we    = r_we && !rst;
    assign w_is_load = (r_op == OP_LW) || (r_op == OP_LH) || (r_op == OP_LHU) ||
                       (r_op == OP_LB) || (r_op == OP_LBU);

    // Alignment of the incoming request: words need a 4-byte, halves a 2-byte boundary.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:          w_misaligned = |req_addr[1:0];
            OP_LH, OP_LHU, OP_SH:  w_misaligned = req_addr[0];
            default:               w_misaligned = 1'b0;
        endcase
    end

    // Lane selection and sign/zero extension of the word currently read from RAM.
    always_comb begin
        w_byte = ram_rdata[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        w_load = ram_rdata;
        case (r_op)
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'h0000, w_half};
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'h000000, w_byte};
            default: w_load = ram_rdata;
        endcase
    end

    // Read-modify-write merge: the fetched word with only the target lane replaced.
    always_comb begin
        w_merged = ram_rdata;
        if (r_op == OP_SB) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // Main controller: all outputs are registered and change only on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_LW;
            r_lane    <= 2'b00;
            r_wdata   <= 16'h0000;
            r_we      <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_lane  <= req_addr[1:0];
                        r_wdata <= req_wdata[15:0];
                        rdata   <= 32'h0;
                        ready   <= 1'b0;
                        if (w_misaligned) begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            err      <= 1'b0;
                            ram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_state  <= S_ACCESS;
                            if (req_op == OP_SW) begin
                                r_we      <= 1'b1;
                                ram_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_is_load || (r_op == OP_SW)) begin
                        if (w_is_load) begin
                            rdata <= w_load;
                        end
                        r_we    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // The merged word is captured here so the RAM read need not be held.
                        ram_wdata <= w_merged;
                        r_we      <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the word-organised data RAM (32-bit words, one combinational read port, one synchronous write port).
- Converts CPU load/store requests (LW, LH, LHU, LB, LBU, SW, SH, SB) into RAM word transactions.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Sits between the multi-cycle datapath's MEM stage and the data RAM.

Parameters:
- ADDR_W, 32, width of CPU and RAM byte addresses.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request strobe; sampled only when ready=1.
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid with done and held until the next accept.
- rdata  out  32  extended load result; valid with done and held until the next accept.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM byte address; word-aligned copy of the captured address.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM combinational read word.

Behaviour:
- States: IDLE, ACCESS, WRITE, DONE.
- Reset: state=IDLE; ready=1; done=0; err=0; rdata=0; ram_we=0; ram_addr=0; ram_wdata=0.
- ram_we is gated with !rst, so no write occurs on a reset edge even if reset arrives in ACCESS or WRITE.
- Reset mid-operation abandons the request with no done pulse.
- Accept: in IDLE with req_valid=1, capture op, addr and wdata at the edge. err and rdata clear on that edge.
- Alignment check at accept:
  - LW/SW require addr[1:0]=00.
  - LH/LHU/SH require addr[0]=0.
  - Byte ops are always aligned.
- Misaligned request: IDLE -> DONE. Set err=1, rdata=0, no RAM write.
- Aligned request: IDLE -> ACCESS. ram_addr = captured addr with bits [1:0] forced to 00, held through ACCESS and WRITE.
- ACCESS, loads: ram_we=0. At the edge, register the extended result into rdata, then -> DONE.
- ACCESS, SW: ram_we=1, ram_wdata=captured wdata; write at the edge, then -> DONE.
- ACCESS, SH/SB: ram_we=0. Latch ram_rdata into an internal word, then -> WRITE.
- WRITE: ram_we=1, ram_wdata = latched word with the target lane replaced, then -> DONE. WRITE is never entered for other ops.
- Little-endian lanes: byte k = bits [8k+7:8k], k=addr[1:0]. Halfword at addr[1]=0 is bits [15:0]; at addr[1]=1 it is bits [31:16].
- Extension:
  - LB/LH sign-extend from bit 7 or bit 15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- DONE: done=1 for exactly one cycle, ready=0, then -> IDLE. The earliest next accept is the cycle after DONE.
- Latency, counting the accept cycle as cycle 0:
  - LW/LH/LHU/LB/LBU/SW: done in cycle 2.
  - SH/SB: done in cycle 3.
  - Misaligned: done in cycle 1.
- req_valid and req_* are ignored outside IDLE; no queuing.
- Outside ACCESS and WRITE: ram_we=0, ram_addr and ram_wdata hold their last values.

Test Plan:
- Reset/idle: assert rst for 2 cycles with req_valid=1 -> ready=1, done=0, ram_we=0 throughout; no accept occurs.
- Word round-trip: SW addr 0x10 data 0xDEADBEEF -> ram_we=1 only in cycle 1, ram_addr=0x10; then LW 0x10 -> rdata=0xDEADBEEF, done in cycle 2, err=0.
- Byte/half loads on word 0x80F17F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LB 0x20 -> 0x00000001.
  - LH 0x22 -> 0xFFFF80F1; LHU 0x20 -> 0x00007F01.
- Sub-word store RMW: word 0x11223344 at 0x30.
  - SB 0x31 data 0xAB -> one ram_we pulse in cycle 2 with ram_wdata=0x1122AB44; done in cycle 3.
  - SH 0x32 data 0x5566 -> word becomes 0x55663344.
- Misalignment: LW 0x41, SH 0x43, SW 0x42 -> each gives done in cycle 1 with err=1, rdata=0, no ram_we; the next aligned op clears err.
- Reset mid-RMW: SB accepted, rst asserted during the WRITE cycle -> no RAM write, no done, state IDLE; RAM word unchanged on readback.
